// File: rtl/keypad_scan_decode_if.sv
// Keypad pin and key-code bundle for keypad_scan_decode.
//   row_n      : keypad rows, active-low, pulled up, asynchronous to clk
//   col_n      : one-hot active-low column drive
//   decode     : stable key code, 0 = no key
//   key_strobe : one-cycle pulse when decode goes 0 -> non-zero
// slave  : the scanner side (drives columns and the key code)
// master : the keypad/consumer side
interface keypad_scan_decode_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] decode;
  logic       key_strobe;

  modport slave  (input row_n, output col_n, output decode, output key_strobe);
  modport master (output row_n, input col_n, input decode, input key_strobe);
endinterface

// File: rtl/keypad_scan_decode.sv
// 4x4 matrix keypad scanner with pass-level debounce and key decoding.
// Ports:
//   clk   : system clock
//   RST   : asynchronous reset, active-high
//   kp_if : keypad_scan_decode_if.slave (row_n in; col_n, decode, key_strobe out)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to enable auto-repeat while a
// key is held (decode drops to 0 for one pass every REPEAT_SCANS passes).
module keypad_scan_decode #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input logic                 clk,
  input logic                 RST,
  keypad_scan_decode_if.slave kp_if
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntMax    = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;
  typedef enum logic [1:0] {ResNone, ResKey, ResMulti} res_e;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;  4'h1: code = 4'd2;  4'h2: code = 4'd3;  4'h3: code = 4'd12;
      4'h4: code = 4'd4;  4'h5: code = 4'd5;  4'h6: code = 4'd6;  4'h7: code = 4'd13;
      4'h8: code = 4'd7;  4'h9: code = 4'd8;  4'hA: code = 4'd9;  4'hB: code = 4'd14;
      4'hC: code = 4'd10; 4'hD: code = 4'd15; 4'hE: code = 4'd11; default: code = 4'd10;
    endcase
    return code;
  endfunction

  logic [3:0]        row_s1_q, row_s2_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        acc_hits_q, acc_hits_d;  // hits so far this pass, saturating at 2
  logic [3:0]        acc_code_q, acc_code_d;
  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        decode_q, decode_d;
  logic              strobe_q, strobe_d;

  logic       sample, pass_end;
  logic [3:0] rows;
  logic [1:0] row_idx, hits_now, hits_sum;
  logic [3:0] code_sum;
  logic       row_one;
  res_e       res;
  logic       is_cand;
  logic [CntW-1:0] cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_SCANS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(REPEAT_SCANS);
  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  logic             gap_q, gap_d;  // decode is in its one-pass repeat gap
  assign hold_inc = hold_q + HoldW'(1);
`else
  logic unused_repeat_scans;
  assign unused_repeat_scans = ^REPEAT_SCANS;
`endif

  assign sample   = (dwell_q == DwellLast);
  assign pass_end = sample && (col_q == 2'd3);
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  // Per-column row evaluation and pass accumulation.
  always_comb begin
    rows    = ~row_s2_q;
    row_one = (rows != 4'd0) && ((rows & (rows - 4'd1)) == 4'd0);
    case (rows)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    hits_now = (rows == 4'd0) ? 2'd0 : (row_one ? 2'd1 : 2'd2);
    if (acc_hits_q == 2'd0)    hits_sum = hits_now;
    else if (hits_now == 2'd0) hits_sum = acc_hits_q;
    else                       hits_sum = 2'd2;
    code_sum = (acc_hits_q == 2'd0) ? key_code(row_idx, col_q) : acc_code_q;
    if (hits_sum == 2'd0)      res = ResNone;
    else if (hits_sum == 2'd1) res = ResKey;
    else                       res = ResMulti;
    is_cand = (res == ResKey) && (code_sum == cand_q);
  end

  // Column dwell and rotation.
  always_comb begin
    dwell_d    = dwell_q + DwellW'(1);
    col_d      = col_q;
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      dwell_d    = '0;
      col_d      = col_q + 2'd1;
      acc_hits_d = pass_end ? 2'd0 : hits_sum;
      acc_code_d = pass_end ? 4'd0 : code_sum;
    end
  end

  // Debounce FSM, evaluated once per completed pass.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    decode_d = decode_q;
    strobe_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d = hold_q;
    gap_d  = gap_q;
`endif
    if (pass_end) begin
      case (state_q)
        StIdle: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          gap_d  = 1'b0;
          hold_d = '0;
`endif
          if (res == ResKey) begin
            cand_d = code_sum;
            if (CntOne == CntMax) begin
              state_d  = StHeld;
              cnt_d    = '0;
              decode_d = code_sum;
              strobe_d = 1'b1;
            end else begin
              state_d = StPressDb;
              cnt_d   = CntOne;
            end
          end
        end
        StPressDb: begin
          if (is_cand) begin
            if (cnt_inc == CntMax) begin
              state_d  = StHeld;
              cnt_d    = '0;
              decode_d = cand_q;
              strobe_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              hold_d = '0;
              gap_d  = 1'b0;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (res == ResNone || (res == ResKey && !is_cand)) begin
            if (CntOne == CntMax) begin
              state_d  = StIdle;
              cnt_d    = '0;
              decode_d = 4'd0;
            end else begin
              state_d = StReleaseDb;
              cnt_d   = CntOne;
            end
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (gap_q) begin
              decode_d = cand_q;
              strobe_d = 1'b1;
              gap_d    = 1'b0;
              hold_d   = '0;
            end else if (hold_inc == HoldMax) begin
              decode_d = 4'd0;
              gap_d    = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_inc;
            end
`endif
          end
        end
        StReleaseDb: begin
          if (is_cand) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (res != ResMulti) begin
            if (cnt_inc == CntMax) begin
              state_d  = StIdle;
              cnt_d    = '0;
              decode_d = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      row_s1_q   <= 4'hF;  // idle rows read high, so no phantom press
      row_s2_q   <= 4'hF;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= StIdle;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      decode_q   <= 4'd0;
      strobe_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q     <= '0;
      gap_q      <= 1'b0;
`endif
    end else begin
      row_s1_q   <= kp_if.row_n;
      row_s2_q   <= row_s1_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      decode_q   <= decode_d;
      strobe_q   <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q     <= hold_d;
      gap_q      <= gap_d;
`endif
    end
  end

  assign kp_if.col_n      = ~(4'b0001 << col_q);
  assign kp_if.decode     = decode_q;
  assign kp_if.key_strobe = strobe_q;

endmodule
